// File: rtl/button_debounce.sv
// Per-button 2-flop synchroniser + debounce FSM producing clean levels and press/release pulses.
// Optional auto-repeat of btn_press while held is enabled by defining BTN_REPEAT_EN.
module button_debounce #(
   parameter int N_BTN           = 5,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter bit INVERT_IN       = 1'b0
`ifdef BTN_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] RPT_ONE        = RPT_W'(1);
   localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_PER_LAST   = RPT_W'(REPEAT_PERIOD - 1);
`endif

   function automatic logic cnt_done(input logic [CNT_W-1:0] c);
      return c == CNT_LAST;
   endfunction

   logic [N_BTN-1:0] sync_p0, sync_p1;

   // Stage p0/p1: two-flop synchroniser of the (optionally inverted) pad inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= btn_raw ^ {N_BTN{INVERT_IN}};
         sync_p1 <= sync_p0;
      end
   end

   // Debounce stage: one independent FSM and counter per button
   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      state_t           state;
      logic [CNT_W-1:0] cnt;
      logic             level_r, press_r, release_r;
      logic             s;
`ifdef BTN_REPEAT_EN
      logic [RPT_W-1:0] rpt_cnt;
      logic             rpt_first;
`endif

      assign s = sync_p1[i];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state     <= IDLE_LO;
            cnt       <= '0;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
`ifdef BTN_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
         end else begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            case (state)
               IDLE_LO: begin
                  if (s) begin
                     state <= WAIT_HI;
                     cnt   <= CNT_ONE;
                  end else begin
                     cnt   <= '0;
                  end
               end
               WAIT_HI: begin
                  if (!s) begin
                     state <= IDLE_LO;
                     cnt   <= '0;
                  end else if (cnt_done(cnt)) begin
                     state   <= IDLE_HI;
                     level_r <= 1'b1;
                     press_r <= 1'b1;
                     cnt     <= '0;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               IDLE_HI: begin
                  if (!s) begin
                     state <= WAIT_LO;
                     cnt   <= CNT_ONE;
`ifdef BTN_REPEAT_EN
                     rpt_cnt   <= '0;
                     rpt_first <= 1'b1;
`endif
                  end
`ifdef BTN_REPEAT_EN
                  // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD
                  else if (rpt_cnt == (rpt_first ? RPT_DELAY_LAST : RPT_PER_LAST)) begin
                     press_r   <= 1'b1;
                     rpt_cnt   <= '0;
                     rpt_first <= 1'b0;
                  end else begin
                     rpt_cnt <= rpt_cnt + RPT_ONE;
                  end
`endif
               end
               WAIT_LO: begin
                  if (s) begin
                     state <= IDLE_HI;
                     cnt   <= '0;
                  end else if (cnt_done(cnt)) begin
                     state     <= IDLE_LO;
                     level_r   <= 1'b0;
                     release_r <= 1'b1;
                     cnt       <= '0;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               default: begin
                  state <= IDLE_LO;
                  cnt   <= '0;
               end
            endcase
         end
      end

      assign btn_level[i]   = level_r;
      assign btn_press[i]   = press_r;
      assign btn_release[i] = release_r;
   end

endmodule
